// File: rtl/itp_tensor_capture.sv
// itp_tensor_capture: grabs one frame of the centred WIN_W x WIN_H window,
// keeps every DEC-th pixel in both axes and stores the OUT_W x OUT_H tensor.
//
// Ports:
//   i_clk, i_rst            pixel clock, async active-high reset
//   i_start                 one-cycle capture request (honoured in IDLE only)
//   i_vsync                 active-low vertical sync from upstream
//   i_valid                 high while an upstream pixel is inside the window
//   i_R, i_G, i_B           colour channels, CW bits each
//   i_rd_addr, o_rd_data    synchronous read port, addr = y*OUT_W+x, 1-cycle latency
//   o_busy                  high while armed or capturing
//   o_done                  one-cycle pulse when a capture completes
//   o_pix_count             pixels written in the current or last capture
//
// Build option: define ITP_GRAY_EN to store 10-bit luminance
// Y=(R+2G+B)>>2 instead of {R,G,B}; reads then return {Y,Y,Y}.

module itp_tensor_capture #(
    parameter int WIN_W = 384,
    parameter int WIN_H = 384,
    parameter int DEC   = 3,
    parameter int OUT_W = WIN_W / DEC,
    parameter int OUT_H = WIN_H / DEC,
    parameter int CW    = 10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_vsync,
    input  logic            i_valid,
    input  logic [CW-1:0]   i_R,
    input  logic [CW-1:0]   i_G,
    input  logic [CW-1:0]   i_B,
    input  logic [13:0]     i_rd_addr,
    output logic [3*CW-1:0] o_rd_data,
    output logic            o_busy,
    output logic            o_done,
    output logic [14:0]     o_pix_count
);

    localparam int PW = (DEC > 1) ? $clog2(DEC) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(DEC - 1);
    localparam logic [8:0]    X_SAT   = 9'(WIN_W);
    localparam logic [8:0]    Y_LAST  = 9'(WIN_H - 1);
    localparam logic [13:0]   OW14    = 14'(OUT_W);
    localparam logic [14:0]   NPIX    = 15'(OUT_W * OUT_H);

`ifdef ITP_GRAY_EN
    localparam int DW = CW;
`else
    localparam int DW = 3 * CW;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic          vsync_q;
    logic          valid_q;
    logic          vs_fall;
    logic          line_end;
    logic          frame_end;
    logic          clear;
    logic          keep;
    logic          x_full;

    logic [8:0]    xc, yc;
    logic [PW-1:0] xph, yph;
    logic [13:0]   ox;
    logic [13:0]   line_base;

    logic          wr_en_q;
    logic [13:0]   wr_addr_q;
    logic [DW-1:0] wr_data_q;
    logic [DW-1:0] pix;

    logic [14:0]   pix_count_q;
    logic [DW-1:0] rd_q;
    logic          rd_ok;

    logic [DW-1:0] mem [0:16383];

`ifdef ITP_GRAY_EN
    logic [CW+1:0] luma_sum;
    assign luma_sum = {2'b00, i_R} + {1'b0, i_G, 1'b0} + {2'b00, i_B};
    assign pix      = DW'(luma_sum >> 2);
    assign o_rd_data = {rd_q, rd_q, rd_q};
`else
    assign pix       = {i_R, i_G, i_B};
    assign o_rd_data = rd_q;
`endif

    assign vs_fall   = vsync_q & ~i_vsync;
    assign line_end  = valid_q & ~i_valid;
    assign x_full    = (xc == X_SAT);
    assign frame_end = (state_q == S_CAPTURE) && line_end && (yc == Y_LAST);
    assign keep      = (state_q == S_CAPTURE) && i_valid && !x_full
                       && (xph == '0) && (yph == '0);

    // Completion wins over a coincident vsync fall; otherwise a fall
    // while armed or capturing (re)starts the frame from scratch.
    assign clear = vs_fall && !frame_end
                   && ((state_q == S_ARM) || (state_q == S_CAPTURE));

    assign rd_ok       = ({1'b0, i_rd_addr} < NPIX);
    assign o_pix_count = pix_count_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                o_busy = 1'b1;
                if (vs_fall) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                o_busy = 1'b1;
                if (frame_end) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vsync_q     <= 1'b1;
            valid_q     <= 1'b0;
            xc          <= '0;
            yc          <= '0;
            xph         <= '0;
            yph         <= '0;
            ox          <= '0;
            line_base   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            pix_count_q <= '0;
        end else begin
            vsync_q <= i_vsync;
            valid_q <= i_valid;
            wr_en_q <= 1'b0;

            if (wr_en_q) begin
                pix_count_q <= pix_count_q + 15'd1;
            end

            if (clear) begin
                xc          <= '0;
                yc          <= '0;
                xph         <= '0;
                yph         <= '0;
                ox          <= '0;
                line_base   <= '0;
                pix_count_q <= '0;
            end else if (state_q == S_CAPTURE) begin
                if (keep) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= line_base + ox;
                    wr_data_q <= pix;
                    ox        <= ox + 14'd1;
                end
                // Pixels past the window edge leave xc parked at WIN_W.
                if (i_valid && !x_full) begin
                    xc  <= xc + 9'd1;
                    xph <= (xph == PH_LAST) ? '0 : xph + 1'b1;
                end
                if (line_end) begin
                    xc  <= '0;
                    xph <= '0;
                    ox  <= '0;
                    yc  <= yc + 9'd1;
                    yph <= (yph == PH_LAST) ? '0 : yph + 1'b1;
                    if (yph == '0) begin
                        line_base <= line_base + OW14;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en_q) begin
            mem[wr_addr_q] <= wr_data_q;
        end
    end

    // Non-blocking read of the array gives old data on a same-address write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_ok ? mem[i_rd_addr] : '0;
        end
    end

endmodule

// File: tb/tb_itp_tensor_capture.sv
// Bench for itp_tensor_capture on a scaled 48x48 window (16x16 tensor).
// Reference model places each kept pixel by the x%3/y%3 rule.

module tb_itp_tensor_capture;

    localparam int W  = 48;
    localparam int H  = 48;
    localparam int D  = 3;
    localparam int OW = W / D;
    localparam int OH = H / D;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        vsync;
    logic        valid;
    logic [9:0]  r, g, b;
    logic [13:0] rd_addr;
    logic [29:0] rd_data;
    logic        busy;
    logic        done;
    logic [14:0] pix_count;

    int checks = 0;
    int passed = 0;
    int done_seen = 0;
    int kept;

    logic [29:0] exp_mem [0:OW*OH-1];

    always #5 clk = ~clk;

    itp_tensor_capture #(
        .WIN_W(W), .WIN_H(H), .DEC(D), .OUT_W(OW), .OUT_H(OH), .CW(10)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_vsync(vsync),
        .i_valid(valid), .i_R(r), .i_G(g), .i_B(b),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data),
        .o_busy(busy), .o_done(done), .o_pix_count(pix_count)
    );

    always @(negedge clk) if (done === 1'b1) done_seen++;

    function automatic logic [29:0] model_word(input int rr, input int gg, input int bb);
        int y;
        logic [9:0] a, c, e;
`ifdef ITP_GRAY_EN
        y = (rr + 2 * gg + bb) / 4;
        a = y[9:0];
        return {a, a, a};
`else
        y = 0;
        a = rr[9:0];
        c = gg[9:0];
        e = bb[9:0];
        return {a, c, e} | 30'(y);
`endif
    endfunction

    task automatic read_word(input int a, output logic [29:0] d);
        rd_addr = a[13:0];
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: R=x G=y B=x^y, 1: random, 2: constant 100/200/300
    task automatic run_frame(input int nlines, input int len0, input int mode,
                             input bit mid_start);
        int len, rr, gg, bb;
        vsync = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_count !== 15'd0 || busy !== 1'b1)
            $display("FAIL vs_clear: pix_count=%0d busy=%b want 0/1", pix_count, busy);
        else passed++;
        @(negedge clk);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        kept = 0;
        for (int y = 0; y < nlines; y++) begin
            len = (y == 0) ? len0 : W;
            for (int x = 0; x < len; x++) begin
                case (mode)
                    0: begin rr = x; gg = y; bb = x ^ y; end
                    1: begin
                        rr = $urandom_range(0, 1023);
                        gg = $urandom_range(0, 1023);
                        bb = $urandom_range(0, 1023);
                    end
                    default: begin rr = 100; gg = 200; bb = 300; end
                endcase
                valid = 1'b1;
                r = rr[9:0];
                g = gg[9:0];
                b = bb[9:0];
                if (x < W && x % D == 0 && y % D == 0) begin
                    exp_mem[(y / D) * OW + x / D] = model_word(rr, gg, bb);
                    kept++;
                end
                @(negedge clk);
            end
            valid = 1'b0;
            r = '0; g = '0; b = '0;
            if (mid_start && y == nlines / 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vsync = 1'b1; valid = 1'b0;
        r = '0; g = '0; b = '0; rd_addr = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pix_count !== 15'd0 || rd_data !== 30'd0)
            $display("FAIL reset_vals: busy=%b done=%b pix=%0d rd=%h want 0", busy, done,
                     pix_count, rd_data);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            valid = i[0];
            r = 10'(i);
            @(negedge clk);
        end
        valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pix_count !== 15'd0 || busy !== 1'b0)
            $display("FAIL idle_valid: pix=%0d busy=%b want 0/0", pix_count, busy);
        else passed++;
    endtask

    task automatic test_full_frame();
        int d0;
        logic [29:0] d;
        d0 = done_seen;
        pulse_start();
        checks++;
        if (busy !== 1'b1) $display("FAIL arm_busy: busy=%b want 1", busy);
        else passed++;
        run_frame(H, W, 0, 0);
        checks++;
        if (done_seen - d0 !== 1 || busy !== 1'b0)
            $display("FAIL full_done: pulses=%0d busy=%b want 1/0", done_seen - d0, busy);
        else passed++;
        checks++;
        if (pix_count !== 15'(OW * OH))
            $display("FAIL full_count: got %0d want %0d", pix_count, OW * OH);
        else passed++;
        read_word(0, d);
        checks++;
        if (d !== model_word(0, 0, 0)) $display("FAIL rd_0: got %h want %h", d, model_word(0, 0, 0));
        else passed++;
        read_word(OW + 1, d);
        checks++;
        if (d !== model_word(3, 3, 0))
            $display("FAIL rd_diag1: got %h want %h", d, model_word(3, 3, 0));
        else passed++;
        read_word(OW * OH - 1, d);
        checks++;
        if (d !== model_word(W - 3, H - 3, 0))
            $display("FAIL rd_last: got %h want %h", d, model_word(W - 3, H - 3, 0));
        else passed++;
    endtask

    task automatic test_overlong();
        int d0, bad;
        logic [29:0] d;
        d0 = done_seen;
        pulse_start();
        run_frame(H, W + 16, 1, 0);
        checks++;
        if (done_seen - d0 !== 1 || pix_count !== 15'(kept))
            $display("FAIL overlong: pulses=%0d pix=%0d want 1/%0d", done_seen - d0,
                     pix_count, kept);
        else passed++;
        bad = 0;
        for (int a = 0; a < OW * OH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                if (bad < 4) $display("FAIL overlong_rd: addr=%0d got %h want %h", a, d, exp_mem[a]);
                bad++;
            end else passed++;
        end
    endtask

    task automatic test_truncated();
        int d0, bad;
        logic [29:0] d;
        d0 = done_seen;
        pulse_start();
        run_frame(13, W, 1, 0);
        checks++;
        if (done_seen !== d0 || busy !== 1'b1 || pix_count !== 15'(kept))
            $display("FAIL trunc_mid: pulses=%0d busy=%b pix=%0d want 0/1/%0d",
                     done_seen - d0, busy, pix_count, kept);
        else passed++;
        run_frame(H, W, 1, 0);
        checks++;
        if (done_seen - d0 !== 1 || pix_count !== 15'(OW * OH))
            $display("FAIL trunc_full: pulses=%0d pix=%0d want 1/%0d", done_seen - d0,
                     pix_count, OW * OH);
        else passed++;
        bad = 0;
        for (int a = 0; a < OW * OH; a++) begin
            read_word(a, d);
            checks++;
            if (d !== exp_mem[a]) begin
                if (bad < 4) $display("FAIL trunc_rd: addr=%0d got %h want %h", a, d, exp_mem[a]);
                bad++;
            end else passed++;
        end
    endtask

    task automatic test_start_during_capture();
        int d0, a;
        logic [29:0] d;
        d0 = done_seen;
        pulse_start();
        run_frame(H, W, 2, 1);
        repeat (20) @(negedge clk);
        checks++;
        if (done_seen - d0 !== 1 || busy !== 1'b0)
            $display("FAIL start_in_cap: pulses=%0d busy=%b want 1/0", done_seen - d0, busy);
        else passed++;
        for (int i = 0; i < 8; i++) begin
            a = $urandom_range(0, OW * OH - 1);
            read_word(a, d);
            checks++;
            if (d !== model_word(100, 200, 300))
                $display("FAIL const_rd: addr=%0d got %h want %h", a, d, model_word(100, 200, 300));
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        run_frame(6, W, 1, 0);
        checks++;
        if (pix_count !== 15'(kept) || busy !== 1'b1)
            $display("FAIL partial_cnt: pix=%0d busy=%b want %0d/1", pix_count, busy, kept);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pix_count !== 15'd0)
            $display("FAIL rst_mid: busy=%b done=%b pix=%0d want 0", busy, done, pix_count);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overlong();
        test_truncated();
        test_start_during_capture();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
